// File: rtl/xy_output_arbiter_pkg.sv
// Shared types for the per-output wormhole arbiter.
// Default sizing matches a full 5-port mesh switch.
package xy_output_arbiter_pkg;

  localparam int ARB_IN_N   = 5;
  localparam int ARB_IN_N_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/xy_output_arbiter_rr_pick.sv
// Rotating priority encoder: first requester at or after ptr.
// Pure combinational; reused by the output arbiter.
module xy_output_arbiter_rr_pick #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] win_o,
  output logic         any_o
);

  logic [W:0] idx;

  // scan ptr, ptr+1, ... modulo N and keep the first hit
  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr_i} + (W+1)'(i);
      if (idx >= (W+1)'(N))
        idx = idx - (W+1)'(N);
      if (!any_o && req_i[idx[W-1:0]]) begin
        win_o = idx[W-1:0];
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xy_output_arbiter.sv
// Per-output wormhole arbiter: round-robin grant,
// locked until the granted input's tail flit leaves.
module xy_output_arbiter
  import xy_output_arbiter_pkg::*;
#(
  parameter int IN_N   = ARB_IN_N,
  parameter int IN_N_W = ARB_IN_N_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IN_N-1:0]   req_i,
  input  logic [IN_N-1:0]   last_i,
  input  logic              out_rdy_i,
  output logic              out_vld_o,
  output logic [IN_N-1:0]   in_rdy_o,
  output logic [IN_N_W-1:0] mux_sel_o,
  output logic              busy_o
);

  arb_state_e        state_q, state_d;
  logic [IN_N_W-1:0] grant_q, grant_d;
  logic [IN_N_W-1:0] ptr_q, ptr_d;
  logic [IN_N_W-1:0] ptr_inc;
  logic [IN_N_W-1:0] win;
  logic              any;
  logic              xfer;
  logic [IN_N-1:0]   grant_oh;

  xy_output_arbiter_rr_pick #(
    .N (IN_N),
    .W (IN_N_W)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .win_o (win),
    .any_o (any)
  );

  assign xfer    = busy_o & req_i[grant_q] & out_rdy_i;
  assign ptr_inc = (grant_q == IN_N_W'(IN_N-1))
                 ? '0 : grant_q + IN_N_W'(1);

  // next state: arbitrate in IDLE, release on tail transfer
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any) begin
          grant_d = win;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (xfer && last_i[grant_q]) begin
          ptr_d   = ptr_inc;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // state, grant and rr pointer registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_oh  = IN_N'(1) << grant_q;
  assign busy_o    = (state_q == ST_BUSY);
  assign out_vld_o = busy_o & req_i[grant_q];
  assign in_rdy_o  = (busy_o & out_rdy_i) ? grant_oh : '0;
  assign mux_sel_o = grant_q;

endmodule
